// File: rtl/leve_rd_arb_pkg.sv
// Shared types and default sizing for the LEVE read-port arbiter.
package leve_rd_arb_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 128;
    localparam int DEF_MAX_OUT = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

    // Requester index width; a single requester still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_if.sv
// Minimal AXI read-channel bundle: AR and R signals only.
interface AXI #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
);
    logic [ADDR_W-1:0] ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [DATA_W-1:0] RDATA;
    logic              RVALID;
    logic              RREADY;

    modport r_init (
        output ARADDR, ARVALID, RREADY,
        input  ARREADY, RDATA, RVALID
    );

    modport r_targ (
        input  ARADDR, ARVALID, RREADY,
        output ARREADY, RDATA, RVALID
    );
endinterface

// File: rtl/leve_rd_order_fifo.sv
// Issue-order FIFO: records which requester owns each outstanding AR.
module leve_rd_order_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   cnt,
    output logic                     empty,
    output logic                     full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             do_pop;

    // The caller guarantees no push while full; pops on empty are ignored.
    assign do_pop = pop && !empty;
    assign empty  = (cnt_reg == '0);
    assign full   = (cnt_reg == CNT_W'(DEPTH));
    assign cnt    = cnt_reg;
    assign head   = mem[rd_ptr_reg];

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
            case ({push, do_pop})
                2'b10:   cnt_reg <= cnt_reg + CNT_W'(1);
                2'b01:   cnt_reg <= cnt_reg - CNT_W'(1);
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

endmodule

// File: rtl/leve_rd_arb.sv
// Round-robin arbiter sharing one single-beat AXI read port among N_REQ
// requesters; R beats are steered back using the issue-order FIFO.
module leve_rd_arb
    import leve_rd_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MAX_OUT = DEF_MAX_OUT
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [N_REQ-1:0][ADDR_W-1:0]  REQ_ARADDR,
    input  logic [N_REQ-1:0]              REQ_ARVALID,
    output logic [N_REQ-1:0]              REQ_ARREADY,
    output logic [DATA_W-1:0]             REQ_RDATA,
    output logic [N_REQ-1:0]              REQ_RVALID,
    input  logic [N_REQ-1:0]              REQ_RREADY,
    AXI.r_init                            RO,
    output logic                          ERR
);
    localparam int IDX_W = idx_w(N_REQ);
    localparam int CNT_W = $clog2(MAX_OUT) + 1;

    arb_state_t        state_reg;
    logic [IDX_W-1:0]  rr_ptr_reg;
    logic [IDX_W-1:0]  gnt_reg;
    logic [ADDR_W-1:0] ar_addr_reg;
    logic              ar_valid_reg;
    logic              err_reg;

    logic [IDX_W-1:0]  sel;
    logic              can_accept;
    logic              accept;
    logic              push;
    logic              pop;
    logic [IDX_W-1:0]  fifo_head;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_empty;
    logic              fifo_full;

    // First valid requester at or after ptr, wrapping; iterating from the far
    // end lets the nearest one overwrite the pick.
    function automatic logic [IDX_W-1:0] rr_select(
        input logic [N_REQ-1:0] valid,
        input logic [IDX_W-1:0] ptr
    );
        logic [IDX_W-1:0] pick;
        int               idx;
        pick = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (valid[idx]) begin
                pick = IDX_W'(idx);
            end
        end
        return pick;
    endfunction

    assign sel        = rr_select(REQ_ARVALID, rr_ptr_reg);
    assign can_accept = (state_reg == IDLE) && (fifo_cnt < CNT_W'(MAX_OUT));
    assign accept     = |(REQ_ARVALID & REQ_ARREADY);
    assign push       = (state_reg == ISSUE) && RO.ARREADY && !fifo_full;
    assign pop        = RO.RVALID && RO.RREADY;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign REQ_ARREADY[gi] = !RST && can_accept && REQ_ARVALID[gi] && (sel == IDX_W'(gi));
        assign REQ_RVALID[gi]  = !RST && RO.RVALID && !fifo_empty && (fifo_head == IDX_W'(gi));
    end

    assign REQ_RDATA  = RO.RDATA;
    assign RO.RREADY  = !RST && !fifo_empty && REQ_RREADY[fifo_head];
    assign RO.ARVALID = ar_valid_reg;
    assign RO.ARADDR  = ar_addr_reg;
    assign ERR        = err_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            gnt_reg      <= '0;
            ar_addr_reg  <= '0;
            ar_valid_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            // A beat with nothing outstanding cannot be attributed; flag it forever.
            if (RO.RVALID && fifo_empty) begin
                err_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        ar_addr_reg  <= REQ_ARADDR[sel];
                        gnt_reg      <= sel;
                        rr_ptr_reg   <= (sel == IDX_W'(N_REQ-1)) ? '0 : sel + IDX_W'(1);
                        ar_valid_reg <= 1'b1;
                        state_reg    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (RO.ARREADY) begin
                        ar_valid_reg <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end
            endcase
        end
    end

    leve_rd_order_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUT)
    ) u_order_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push),
        .din   (gnt_reg),
        .pop   (pop),
        .head  (fifo_head),
        .cnt   (fifo_cnt),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: doc/leve_rd_arb.md
# leve_rd_arb

Round-robin arbiter that shares one AXI read-initiator port between `N_REQ` internal requesters, e.g. instruction fetch and vector load. It sits between the LEVE core's load sources and the memory-side `AXI.r_init` port. It registers the winning address onto the shared AR channel and tracks issue order in an order FIFO. Each returning R beat is steered back to the requester that issued it. All transfers are single-beat and use a single AXI ID, so responses return in issue order.

## Interface
- `N_REQ`, 2: number of requesters, at least 2.
- `ADDR_W`, 32: address width.
- `DATA_W`, 128: read data width; one beat covers 0x10 bytes.
- `MAX_OUT`, 4: maximum outstanding ARs; must be a power of 2.
- Reset is synchronous and active-high.

Ports:
- `CLK`  in  1  clock; all logic on posedge.
- `RST`  in  1  synchronous active-high reset.
- `REQ_ARADDR`  in  `N_REQ`×`ADDR_W`  per-requester read address.
- `REQ_ARVALID`  in  `N_REQ`  per-requester address valid.
- `REQ_ARREADY`  out  `N_REQ`  per-requester address accepted.
- `REQ_RDATA`  out  `DATA_W`  read data, broadcast to all requesters.
- `REQ_RVALID`  out  `N_REQ`  read data valid, one-hot toward the owner.
- `REQ_RREADY`  in  `N_REQ`  per-requester read ready.
- `RO`  `AXI.r_init`  shared memory-side read channel; uses ARADDR, ARVALID, ARREADY, RDATA, RVALID, RREADY.
- `ERR`  out  1  sticky protocol error.

## Operation
- State machine with two states: `IDLE` and `ISSUE`.
- In `IDLE`:
  - `sel` is the lowest requester index at or after `rr_ptr` (wrapping) whose ARVALID is high.
  - `REQ_ARREADY[sel] = (fifo_cnt < MAX_OUT)`; all other `REQ_ARREADY` bits are 0.
  - On a requester handshake: latch its address into `ar_addr`, latch `sel` into `gnt`, set `rr_ptr <= (sel+1) mod N_REQ`, go to `ISSUE`.
- In `ISSUE`:
  - `RO.ARVALID=1` and `RO.ARADDR=ar_addr`, held stable until `RO.ARREADY`.
  - All `REQ_ARREADY` bits are 0.
  - On `RO.ARREADY`: push `gnt` into the order FIFO and return to `IDLE`.
- R steering:
  - `head` is the order-FIFO front entry.
  - `REQ_RDATA = RO.RDATA` always.
  - `REQ_RVALID[i] = RO.RVALID && !empty && head==i`.
  - `RO.RREADY = !empty && REQ_RREADY[head]`.
  - Pop the FIFO on the `RO.RVALID && RO.RREADY` handshake.
- FIFO boundaries:
  - Push and pop in the same cycle are allowed; `fifo_cnt` is unchanged.
  - An accept is never possible while `fifo_cnt==MAX_OUT`, even if a pop happens in the same cycle. This is decided, and it makes overflow impossible.
  - Pointers wrap modulo `MAX_OUT`.
  - `fifo_cnt` is `$clog2(MAX_OUT)+1` bits wide.
- Error handling:
  - `RO.RVALID` with an empty FIFO is a protocol error: set `ERR`, which stays set until `RST`.
  - `RO.RREADY` remains 0 in that case; the beat is not consumed.
- Reset values:
  - Outputs: `RO.ARVALID=0`, `RO.ARADDR=0`, `REQ_ARREADY=0`, `REQ_RVALID=0`, `RO.RREADY=0`, `ERR=0`.
  - Internal: state `IDLE`, `rr_ptr=0`, `fifo_cnt=0`.
  - `RST` mid-operation discards all outstanding tracking; the environment must quiesce the memory side as well.

## Timing
- AR latency: requester handshake in cycle t → `RO.ARVALID` high in cycle t+1.
- Peak AR throughput: one per 2 cycles (`IDLE`→`ISSUE`→`IDLE`).
- `REQ_ARREADY` is combinational from `REQ_ARVALID`, `rr_ptr` and `fifo_cnt`. It has no dependency on `RO.ARREADY`.
- R path is fully combinational, with 0 cycles added: `RO.RVALID` → `REQ_RVALID`, and `REQ_RREADY` → `RO.RREADY`.
- `RO.ARVALID` never deasserts before `RO.ARREADY`; `ar_addr` is stable throughout `ISSUE`.

## Structure
- Package `leve_rd_arb_pkg` holds:
  - the state enum (`IDLE`, `ISSUE`);
  - the `IDX_W=$clog2(N_REQ)` helper;
  - default constants for `ADDR_W`, `DATA_W` and `MAX_OUT`.
- Sub-module `leve_rd_order_fifo`:
  - synchronous FIFO of `IDX_W`-bit entries, depth `MAX_OUT`;
  - ports push, pop, `head`, `cnt`, `empty`, `full`;
  - same `CLK`/`RST`.
- Round-robin select is a combinational function in the top module.

## Test plan
- Reset check: assert `RST` 2 cycles → all outputs 0. Requester 0 then issues `0x8000_0000` → `RO.ARADDR=0x8000_0000` with `ARVALID` one cycle after its handshake.
- Contention: both requesters hold ARVALID (req0 `0x8000_0000`, req1 `0x9000_0000`) with `ARREADY=1` → grants alternate 0,1,0,1. R beats return in that order, each raising only the owner's `REQ_RVALID`.
- AR stall: `RO.ARREADY=0` for 5 cycles → `ARADDR`/`ARVALID` stable, all `REQ_ARREADY=0`. Release → exactly one push.
- Outstanding limit: `MAX_OUT=4`, with no R returned after 4 ARs → 5th request sees `REQ_ARREADY=0`. One R beat then re-enables acceptance on the next cycle.
- R backpressure: owner 1 holds `REQ_RREADY=0` for 3 cycles while head==1 → `RO.RREADY=0` and `RDATA` is held by memory. Requester 0's later beat is not delivered early.
- Errors and reset: `RO.RVALID=1` with an empty FIFO → `ERR=1` from the next cycle and sticky until `RST`. A `RST` pulse during `ISSUE` returns the block to `IDLE` with `ARVALID=0`, `fifo_cnt=0` and `rr_ptr=0`.
